spi_slave: RTL and testbench

SPI peripheral-side (slave) endpoint that pairs with the existing SPI master. It oversamples the external SCLK, CS_N and MOSI pins on the system clock and shifts a frame of 8/16/24/32 bits in and out. It supports all four SPI modes and either bit order, and takes the same spi_config_t as the master. It sits on the peripheral bus: the CPU preloads tx_data and collects rx_data through a valid/ack handshake.

---
 rtl/spi_slave_pkg.sv | 56 +++++
 rtl/spi_slave_pin_sync.sv | 34 +++
 rtl/spi_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI configuration types, encodings and bit-position helpers
package spi_slave_pkg;

    localparam logic [1:0] SPI_MODE_0 = 2'd0;
    localparam logic [1:0] SPI_MODE_1 = 2'd1;
    localparam logic [1:0] SPI_MODE_2 = 2'd2;
    localparam logic [1:0] SPI_MODE_3 = 2'd3;

    localparam logic [1:0] SPI_FRAME_SIZE_8  = 2'd0;
    localparam logic [1:0] SPI_FRAME_SIZE_16 = 2'd1;
    localparam logic [1:0] SPI_FRAME_SIZE_24 = 2'd2;
    localparam logic [1:0] SPI_FRAME_SIZE_32 = 2'd3;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    typedef struct packed {
        logic [15:0] prescaler;
        logic [1:0]  spi_mode;
        logic [1:0]  spi_frame_size;
        logic        bit_order;
    } spi_config_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMPLETE,
        WAIT_CS
    } spi_slave_state_t;

    // Frame length in bits; unknown encodings fall back to 8.
    function automatic logic [5:0] frame_bits(input logic [1:0] fs);
        logic [5:0] n;
        case (fs)
            SPI_FRAME_SIZE_16: n = 6'd16;
            SPI_FRAME_SIZE_24: n = 6'd24;
            SPI_FRAME_SIZE_32: n = 6'd32;
            default:           n = 6'd8;
        endcase
        return n;
    endfunction

    // Position in the right-justified word of the idx-th bit on the wire.
    function automatic logic [4:0] bit_pos(input logic [4:0] idx,
                                           input logic [5:0] nbits,
                                           input logic       order);
        logic [5:0] p;
        if (order == MSB_FIRST) begin
            p = nbits - 6'd1 - {1'b0, idx};
        end else begin
            p = {1'b0, idx};
        end
        return p[4:0];
    endfunction

endpackage

// File: rtl/spi_slave_pin_sync.sv
// rtl/spi_slave_pin_sync.sv - multi-flop pin synchronizer with rise/fall pulses
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   pin        asynchronous input pin
//   rise/fall  one-cycle pulses, SYNC_STAGES+1 cycles after the pin edge
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            hist_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI slave endpoint, modes 0-3, 8/16/24/32-bit frames
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   spi_config           mode, frame size, bit order (prescaler unused)
//   sclk, cs_n, mosi     asynchronous SPI pins from the master
//   miso, miso_oe        serial data out and its tristate enable
//   tx_data              frame to send, latched at cs_n fall
//   rx_data, rx_valid    last received frame and its valid flag
//   rx_ack               consumes rx_data, clears rx_valid and overrun
//   overrun              sticky: frame completed while rx_valid was high
//   abort                one-cycle pulse when cs_n rises mid-frame
//   busy                 FSM is not IDLE
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  spi_config_t spi_config,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        overrun,
    output logic        abort,
    output logic        busy
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclk_sync (
        .clk (clk),
        .rst (rst),
        .pin (sclk),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .pin (cs_n),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    // mosi gets the same depth as sclk so data and edge pulses stay aligned;
    // the extra flop matches the history stage used for edge detection.
    logic [SYNC_STAGES:0] mosi_sync_q;
    logic                 mosi_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic unused_cfg;
    assign unused_cfg = ^{spi_config.prescaler, mosi_sync_q[SYNC_STAGES]};

    spi_slave_state_t state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  fs_q, fs_d;
    logic        order_q, order_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [4:0]  bit_index_q, bit_index_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        abort_q, abort_d;

    logic        cpol, cpha, lead_edge, trail_edge, last_bit;
    logic [5:0]  nbits, nbits_in;
    logic [4:0]  cur_pos, next_pos, first_pos;
    logic [31:0] frame_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= SPI_MODE_0;
            fs_q        <= SPI_FRAME_SIZE_8;
            order_q     <= MSB_FIRST;
            tx_q        <= '0;
            rx_shift_q  <= '0;
            bit_index_q <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fs_q        <= fs_d;
            order_q     <= order_d;
            tx_q        <= tx_d;
            rx_shift_q  <= rx_shift_d;
            bit_index_q <= bit_index_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    // Leading edge moves sclk away from its idle level (cpol).
    assign cpol       = mode_q[1];
    assign cpha       = mode_q[0];
    assign lead_edge  = cpol ? sclk_fall : sclk_rise;
    assign trail_edge = cpol ? sclk_rise : sclk_fall;

    assign nbits     = frame_bits(fs_q);
    assign nbits_in  = frame_bits(spi_config.spi_frame_size);
    assign cur_pos   = bit_pos(bit_index_q, nbits, order_q);
    assign next_pos  = bit_pos(bit_index_q + 5'd1, nbits, order_q);
    assign first_pos = bit_pos(5'd0, nbits_in, spi_config.bit_order);
    assign last_bit  = ({1'b0, bit_index_q} == (nbits - 6'd1));

    always_comb begin
        case (fs_q)
            SPI_FRAME_SIZE_16: frame_mask = 32'h0000_FFFF;
            SPI_FRAME_SIZE_24: frame_mask = 32'h00FF_FFFF;
            SPI_FRAME_SIZE_32: frame_mask = 32'hFFFF_FFFF;
            default:           frame_mask = 32'h0000_00FF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fs_d        = fs_q;
        order_d     = order_q;
        tx_d        = tx_q;
        rx_shift_d  = rx_shift_q;
        bit_index_d = bit_index_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        abort_d     = 1'b0;

        if (rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    mode_d      = spi_config.spi_mode;
                    fs_d        = spi_config.spi_frame_size;
                    order_d     = spi_config.bit_order;
                    tx_d        = tx_data;
                    rx_shift_d  = '0;
                    bit_index_d = '0;
                    miso_oe_d   = 1'b1;
                    miso_d      = tx_data[first_pos];
                    state_d     = SHIFT;
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    abort_d   = 1'b1;
                    miso_oe_d = 1'b0;
                    state_d   = IDLE;
                end else if (lead_edge) begin
                    if (cpha) begin
                        miso_d = tx_q[cur_pos];
                    end else begin
                        rx_shift_d[cur_pos] = mosi_s;
                    end
                end else if (trail_edge) begin
                    if (cpha) begin
                        rx_shift_d[cur_pos] = mosi_s;
                    end
                    if (last_bit) begin
                        state_d = COMPLETE;
                    end else begin
                        bit_index_d = bit_index_q + 5'd1;
                        if (!cpha) begin
                            miso_d = tx_q[next_pos];
                        end
                    end
                end
            end

            COMPLETE: begin
                rx_data_d  = rx_shift_q & frame_mask;
                rx_valid_d = 1'b1;
                // A simultaneous ack neither clears nor sets overrun.
                overrun_d  = rx_ack ? overrun_q : (overrun_q | rx_valid_q);
                if (cs_rise) begin
                    miso_oe_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d   = WAIT_CS;
                end
            end

            WAIT_CS: begin
                if (cs_rise) begin
                    miso_oe_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign abort    = abort_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int HALF = 5;

    logic        clk;
    logic        rst;
    spi_config_t cfg;
    logic        sclk, cs_n, mosi;
    logic        miso, miso_oe;
    logic [31:0] tx_data, rx_data;
    logic        rx_valid, rx_ack, overrun, abort, busy;

    int vectors     = 0;
    int miscompares = 0;
    int abort_cycles = 0;
    int abort_before;
    logic [31:0] mrx;
    logic [1:0]  modes [3];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_config(cfg),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .overrun   (overrun),
        .abort     (abort),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (abort) abort_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [1:0] fs, input logic order);
        cfg.prescaler      = 16'd0;
        cfg.spi_mode       = mode;
        cfg.spi_frame_size = fs;
        cfg.bit_order      = order;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Master model: clocks nclk bits of an nbits frame, optionally leaving cs_n low.
    task automatic spi_xfer(input logic [1:0] mode, input int nbits, input logic lsb,
                            input logic [31:0] mtx, input int nclk, input bit release_cs,
                            output logic [31:0] rxw);
        logic cp, ch;
        int   p;
        cp   = mode[1];
        ch   = mode[0];
        rxw  = '0;
        sclk = cp;
        repeat (6) @(negedge clk);
        cs_n = 1'b0;
        p = lsb ? 0 : nbits - 1;
        if (!ch) mosi = mtx[p[4:0]];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            p = lsb ? i : nbits - 1 - i;
            if (ch) begin
                mosi = mtx[p[4:0]];
                sclk = ~cp;
                repeat (HALF) @(negedge clk);
                rxw[p[4:0]] = miso;
                sclk = cp;
                repeat (HALF) @(negedge clk);
            end else begin
                rxw[p[4:0]] = miso;
                sclk = ~cp;
                repeat (HALF) @(negedge clk);
                sclk = cp;
                if (i + 1 < nbits) begin
                    p = lsb ? i + 1 : nbits - 2 - i;
                    mosi = mtx[p[4:0]];
                end
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        if (release_cs) begin
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        rst     = 1'b1;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        rx_ack  = 1'b0;
        tx_data = '0;
        set_cfg(SPI_MODE_0, SPI_FRAME_SIZE_8, MSB_FIRST);
        modes[0] = SPI_MODE_3;
        modes[1] = SPI_MODE_1;
        modes[2] = SPI_MODE_2;

        #1;
        check("reset_miso",     32'(miso),     32'd0);
        check("reset_miso_oe",  32'(miso_oe),  32'd0);
        check("reset_rx_data",  rx_data,       32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_overrun",  32'(overrun),  32'd0);
        check("reset_abort",    32'(abort),    32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0, 8-bit, MSB first
        set_cfg(SPI_MODE_0, SPI_FRAME_SIZE_8, MSB_FIRST);
        tx_data = 32'h0000_003C;
        spi_xfer(SPI_MODE_0, 8, 1'b0, 32'h0000_00A5, 8, 1'b1, mrx);
        check("m0_rx_data",  rx_data,       32'h0000_00A5);
        check("m0_rx_valid", 32'(rx_valid), 32'd1);
        check("m0_master",   mrx,           32'h0000_003C);
        check("m0_busy",     32'(busy),     32'd0);
        check("m0_miso_oe",  32'(miso_oe),  32'd0);
        ack();
        check("m0_ack",      32'(rx_valid), 32'd0);

        // 32-bit LSB first in modes 3, 1, 2
        for (int k = 0; k < 3; k++) begin
            set_cfg(modes[k], SPI_FRAME_SIZE_32, LSB_FIRST);
            tx_data = 32'h1234_5678;
            spi_xfer(modes[k], 32, 1'b1, 32'hDEAD_BEEF, 32, 1'b1, mrx);
            check($sformatf("m%0d_rx32", modes[k]),     rx_data, 32'hDEAD_BEEF);
            check($sformatf("m%0d_master32", modes[k]), mrx,     32'h1234_5678);
            check($sformatf("m%0d_overrun", modes[k]),  32'(overrun), 32'd0);
            ack();
        end

        // Back-to-back 16-bit frames without ack
        set_cfg(SPI_MODE_1, SPI_FRAME_SIZE_16, MSB_FIRST);
        tx_data = 32'h0000_BEEF;
        spi_xfer(SPI_MODE_1, 16, 1'b0, 32'h0000_1111, 16, 1'b1, mrx);
        check("ov_first_overrun", 32'(overrun), 32'd0);
        spi_xfer(SPI_MODE_1, 16, 1'b0, 32'h0000_2222, 16, 1'b1, mrx);
        check("ov_rx_data",  rx_data,       32'h0000_2222);
        check("ov_overrun",  32'(overrun),  32'd1);
        check("ov_rx_valid", 32'(rx_valid), 32'd1);
        check("ov_master",   mrx,           32'h0000_BEEF);
        ack();
        check("ov_ack_valid",   32'(rx_valid), 32'd0);
        check("ov_ack_overrun", 32'(overrun),  32'd0);

        // Abort after 5 SCLK cycles, then a full frame
        set_cfg(SPI_MODE_0, SPI_FRAME_SIZE_8, MSB_FIRST);
        tx_data = 32'h0000_00C3;
        abort_before = abort_cycles;
        spi_xfer(SPI_MODE_0, 8, 1'b0, 32'h0000_00FF, 5, 1'b1, mrx);
        check("ab_pulse_len", 32'(abort_cycles - abort_before), 32'd1);
        check("ab_rx_data",   rx_data,       32'h0000_2222);
        check("ab_rx_valid",  32'(rx_valid), 32'd0);
        check("ab_busy",      32'(busy),     32'd0);
        check("ab_miso_oe",   32'(miso_oe),  32'd0);
        spi_xfer(SPI_MODE_0, 8, 1'b0, 32'h0000_005A, 8, 1'b1, mrx);
        check("ab_next_rx",     rx_data, 32'h0000_005A);
        check("ab_next_master", mrx,     32'h0000_00C3);
        check("ab_next_valid",  32'(rx_valid), 32'd1);

        // Asynchronous reset at bit 10 of a 24-bit frame
        set_cfg(SPI_MODE_0, SPI_FRAME_SIZE_24, MSB_FIRST);
        tx_data = 32'h0012_3456;
        spi_xfer(SPI_MODE_0, 24, 1'b0, 32'h00AB_CDEF, 10, 1'b0, mrx);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_miso",     32'(miso),     32'd0);
        check("rst_mid_miso_oe",  32'(miso_oe),  32'd0);
        check("rst_mid_rx_data",  rx_data,       32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_overrun",  32'(overrun),  32'd0);
        check("rst_mid_abort",    32'(abort),    32'd0);
        check("rst_mid_busy",     32'(busy),     32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        spi_xfer(SPI_MODE_0, 24, 1'b0, 32'h00AB_CDEF, 24, 1'b1, mrx);
        check("rst_next_rx24",  rx_data, 32'h00AB_CDEF);
        check("rst_next_master", mrx,    32'h0012_3456);
        ack();

        // Config and tx_data change mid-frame are ignored until next cs_n fall
        set_cfg(SPI_MODE_0, SPI_FRAME_SIZE_8, MSB_FIRST);
        tx_data = 32'h0000_0096;
        fork
            spi_xfer(SPI_MODE_0, 8, 1'b0, 32'h0000_0069, 8, 1'b1, mrx);
            begin
                repeat (20) @(negedge clk);
                check("chg_busy",    32'(busy),    32'd1);
                check("chg_miso_oe", 32'(miso_oe), 32'd1);
                set_cfg(SPI_MODE_3, SPI_FRAME_SIZE_32, LSB_FIRST);
                tx_data = 32'hFFFF_FFFF;
            end
        join
        check("chg_rx_data", rx_data, 32'h0000_0069);
        check("chg_master",  mrx,     32'h0000_0096);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
